// File: rtl/kl_arbiter.sv
// rtl/kl_arbiter.sv - round-robin N:1 KL request arbiter with per-master read credit limit
// Registered request slot toward the downstream port; responses are routed back combinationally by dstid.
module kl_arbiter #(
  parameter  int NUM_MASTERS = 2,
  parameter  int SRCID_W     = 5,
  parameter  int MAX_OUTST   = 4,
  localparam int IDX_W       = $clog2(NUM_MASTERS),
  localparam int LID_W       = SRCID_W - IDX_W
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [NUM_MASTERS*32-1:0]    m_req_addr,
  input  logic [NUM_MASTERS-1:0]       m_req_wen,
  input  logic [NUM_MASTERS*64-1:0]    m_req_wdata,
  input  logic [NUM_MASTERS*8-1:0]     m_req_wmask,
  input  logic [NUM_MASTERS*3-1:0]     m_req_size,
  input  logic [NUM_MASTERS*LID_W-1:0] m_req_srcid,
  input  logic [NUM_MASTERS-1:0]       m_req_valid,
  output logic [NUM_MASTERS-1:0]       m_req_ready,

  output logic [63:0]                  m_resp_rdata,
  output logic [2:0]                   m_resp_size,
  output logic [LID_W-1:0]             m_resp_dstid,
  output logic [NUM_MASTERS-1:0]       m_resp_valid,
  input  logic [NUM_MASTERS-1:0]       m_resp_ready,

  output logic [31:0]                  s_req_addr,
  output logic                         s_req_wen,
  output logic [63:0]                  s_req_wdata,
  output logic [7:0]                   s_req_wmask,
  output logic [2:0]                   s_req_size,
  output logic [SRCID_W-1:0]           s_req_srcid,
  output logic                         s_req_valid,
  input  logic                         s_req_ready,

  input  logic [63:0]                  s_resp_rdata,
  input  logic [2:0]                   s_resp_size,
  input  logic [SRCID_W-1:0]           s_resp_dstid,
  input  logic                         s_resp_valid,
  output logic                         s_resp_ready
);

  logic [IDX_W-1:0]       last_grant;
  logic [3:0]             outst [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] inc;
  logic [NUM_MASTERS-1:0] dec;
  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       resp_idx;
  logic                   found;
  logic                   can_accept;
  logic                   accept;
  int                     cand;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = m_req_valid[i] & (m_req_wen[i] | (outst[i] < 4'(MAX_OUTST)));
    end
  end

  // Rotating priority: the master after last_grant is searched first.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = (int'(last_grant) + off) % NUM_MASTERS;
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  assign can_accept = !s_req_valid || s_req_ready;
  assign accept     = can_accept && found;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_req_ready[i] = rst_n && accept && (win == IDX_W'(i));
      inc[i]         = accept && (win == IDX_W'(i)) && !m_req_wen[i];
      dec[i]         = m_resp_valid[i] && m_resp_ready[i];
    end
  end

  assign resp_idx     = s_resp_dstid[SRCID_W-1 -: IDX_W];
  assign m_resp_rdata = s_resp_rdata;
  assign m_resp_size  = s_resp_size;
  assign m_resp_dstid = s_resp_dstid[LID_W-1:0];

  // Responses addressed to a nonexistent master are swallowed so the downstream never stalls.
  always_comb begin
    s_resp_ready = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_resp_valid[i] = s_resp_valid && (resp_idx == IDX_W'(i));
      if (resp_idx == IDX_W'(i)) s_resp_ready = m_resp_ready[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_req_valid <= 1'b0;
      last_grant  <= IDX_W'(NUM_MASTERS - 1);
      for (int i = 0; i < NUM_MASTERS; i++) outst[i] <= 4'd0;
    end else begin
      if (accept) begin
        s_req_valid <= 1'b1;
        last_grant  <= win;
      end else if (s_req_ready) begin
        s_req_valid <= 1'b0;
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (inc[i] && !dec[i]) outst[i] <= outst[i] + 4'd1;
        else if (dec[i] && !inc[i] && outst[i] != 4'd0) outst[i] <= outst[i] - 4'd1;
      end
    end
  end

  // Payload needs no reset: it is only observed while s_req_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s_req_addr  <= m_req_addr[win*32 +: 32];
      s_req_wen   <= m_req_wen[win];
      s_req_wdata <= m_req_wdata[win*64 +: 64];
      s_req_wmask <= m_req_wmask[win*8 +: 8];
      s_req_size  <= m_req_size[win*3 +: 3];
      s_req_srcid <= {win, m_req_srcid[win*LID_W +: LID_W]};
    end
  end

endmodule

// File: tb/tb_kl_arbiter.sv
// tb/tb_kl_arbiter.sv - directed self-checking bench for kl_arbiter (2 masters, 5-bit srcid, 4 reads outstanding)
module tb_kl_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  m_req_addr;
  logic [1:0]   m_req_wen;
  logic [127:0] m_req_wdata;
  logic [15:0]  m_req_wmask;
  logic [5:0]   m_req_size;
  logic [7:0]   m_req_srcid;
  logic [1:0]   m_req_valid;
  logic [1:0]   m_req_ready;
  logic [63:0]  m_resp_rdata;
  logic [2:0]   m_resp_size;
  logic [3:0]   m_resp_dstid;
  logic [1:0]   m_resp_valid;
  logic [1:0]   m_resp_ready;
  logic [31:0]  s_req_addr;
  logic         s_req_wen;
  logic [63:0]  s_req_wdata;
  logic [7:0]   s_req_wmask;
  logic [2:0]   s_req_size;
  logic [4:0]   s_req_srcid;
  logic         s_req_valid;
  logic         s_req_ready;
  logic [63:0]  s_resp_rdata;
  logic [2:0]   s_resp_size;
  logic [4:0]   s_resp_dstid;
  logic         s_resp_valid;
  logic         s_resp_ready;

  int n_checks = 0;
  int n_errors = 0;

  kl_arbiter #(.NUM_MASTERS(2), .SRCID_W(5), .MAX_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_addr(m_req_addr), .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata),
    .m_req_wmask(m_req_wmask), .m_req_size(m_req_size), .m_req_srcid(m_req_srcid),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_resp_rdata(m_resp_rdata), .m_resp_size(m_resp_size), .m_resp_dstid(m_resp_dstid),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .s_req_addr(s_req_addr), .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata),
    .s_req_wmask(s_req_wmask), .s_req_size(s_req_size), .s_req_srcid(s_req_srcid),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_resp_rdata(s_resp_rdata), .s_resp_size(s_resp_size), .s_resp_dstid(s_resp_dstid),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    m_req_addr   = {32'h2000_0000, 32'h1000_0000};
    m_req_wen    = 2'b00;
    m_req_wdata  = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    m_req_wmask  = 16'hFF0F;
    m_req_size   = {3'd3, 3'd2};
    m_req_srcid  = {4'h5, 4'h3};
    m_req_valid  = 2'b11;
    m_resp_ready = 2'b00;
    s_req_ready  = 1'b0;
    s_resp_rdata = 64'h0;
    s_resp_size  = 3'd0;
    s_resp_dstid = 5'h00;
    s_resp_valid = 1'b0;

    #2;
    chk("rst_s_req_valid", s_req_valid, 0);
    chk("rst_m_req_ready", m_req_ready, 0);

    // Alternating grants with both masters reading continuously
    @(negedge clk);
    rst_n = 1'b1;
    s_req_ready = 1'b1;
    #1 chk("rr_first_ready", m_req_ready, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_valid", s_req_valid, 1);
      chk("rr_srcid", s_req_srcid, (k % 2 == 1) ? 5'h15 : 5'h03);
      chk("rr_addr", s_req_addr, (k % 2 == 1) ? 32'h2000_0000 : 32'h1000_0000);
      #1 chk("rr_ready", m_req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Stall for three cycles: slot frozen, no ready even though inputs change
    s_req_ready = 1'b0;
    m_req_addr  = {32'hAAAA_0000, 32'hBBBB_0000};
    #1 chk("stall_ready0", m_req_ready, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", s_req_valid, 1);
      chk("stall_srcid", s_req_srcid, 5'h15);
      chk("stall_addr", s_req_addr, 32'h2000_0000);
      chk("stall_ready", m_req_ready, 2'b00);
    end
    s_req_ready = 1'b1;
    m_req_valid = 2'b00;
    @(negedge clk);
    chk("drain_valid", s_req_valid, 0);

    // Read credit limit on master 0
    rst_n = 1'b0;
    m_req_addr = {32'h2000_0000, 32'h1000_0000};
    @(negedge clk);
    rst_n = 1'b1;
    m_req_valid = 2'b01;
    #1 chk("cred_ready_init", m_req_ready, 2'b01);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1 chk("cred_ready", m_req_ready, (j < 3) ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    chk("cred_no_5th_valid", s_req_valid, 0);
    #1 chk("cred_no_5th_ready", m_req_ready, 2'b00);
    m_req_wen = 2'b01;
    #1 chk("cred_write_ok", m_req_ready, 2'b01);
    m_req_wen = 2'b00;
    #1 chk("cred_read_blocked", m_req_ready, 2'b00);

    s_resp_valid = 1'b1;
    s_resp_dstid = 5'h07;
    s_resp_rdata = 64'hDEAD_BEEF_0123_4567;
    s_resp_size  = 3'd3;
    m_resp_ready = 2'b01;
    #1;
    chk("resp0_valid", m_resp_valid, 2'b01);
    chk("resp0_sready", s_resp_ready, 1);
    chk("resp0_dstid", m_resp_dstid, 4'h7);
    chk("resp0_rdata", m_resp_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("resp0_req_blocked", m_req_ready, 2'b00);
    @(negedge clk);
    s_resp_valid = 1'b0;
    #1 chk("cred_regrant_ready", m_req_ready, 2'b01);
    @(negedge clk);
    chk("cred_regrant_valid", s_req_valid, 1);
    #1 chk("cred_full_again", m_req_ready, 2'b00);

    // Accept and response in the same cycle leave the count unchanged
    s_resp_valid = 1'b1;
    @(negedge clk);
    #1 chk("sim_ready_pre", m_req_ready, 2'b01);
    @(negedge clk);
    chk("sim_valid", s_req_valid, 1);
    s_resp_valid = 1'b0;
    #1 chk("sim_ready_post", m_req_ready, 2'b01);
    @(negedge clk);
    #1 chk("sim_full", m_req_ready, 2'b00);

    // Response routing to master 1 and decrement saturation at zero
    m_req_valid  = 2'b00;
    s_resp_valid = 1'b1;
    s_resp_dstid = 5'h13;
    m_resp_ready = 2'b10;
    #1;
    chk("route1_valid", m_resp_valid, 2'b10);
    chk("route1_dstid", m_resp_dstid, 4'h3);
    chk("route1_sready", s_resp_ready, 1);
    m_resp_ready = 2'b01;
    #1 chk("route1_backpressure", s_resp_ready, 0);
    m_resp_ready = 2'b10;
    @(negedge clk);
    s_resp_valid = 1'b0;
    m_req_valid  = 2'b10;
    #1 chk("sat_ready", m_req_ready, 2'b10);
    @(negedge clk);
    chk("sat_valid", s_req_valid, 1);
    chk("sat_srcid", s_req_srcid, 5'h15);

    // Reset while the slot is occupied
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", s_req_valid, 0);
    chk("midrst_ready", m_req_ready, 2'b00);
    m_req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("postrst_ready", m_req_ready, 2'b01);
    @(negedge clk);
    chk("postrst_valid", s_req_valid, 1);
    chk("postrst_srcid", s_req_srcid, 5'h03);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kl_arbiter.md
KL_ARBITER -- requirements
Module: kl_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of KL requesters (legal values 2..8).
REQ-002 SHALL have parameter SRCID_W, default 5, KL srcid/dstid width.
REQ-003 SHALL have parameter MAX_OUTST, default 4, maximum outstanding reads per master (legal values 1..15).
REQ-004 SHALL derive IDX_W = clog2(NUM_MASTERS) and LID_W = SRCID_W-IDX_W; LID_W is at least 1.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset; one clock; asynchronous, active-low.
REQ-007 m_req_addr/wen/wdata/wmask/size  in  NUM_MASTERS x (32/1/64/8/3)  per-master request fields, packed, master i in slice i.
REQ-008 m_req_srcid  in  NUM_MASTERS*LID_W  per-master local id.
REQ-009 m_req_valid in, m_req_ready out  NUM_MASTERS  per-master request handshake.
REQ-010 m_resp_rdata/size/dstid  out  64/3/LID_W  response fields broadcast to all masters; dstid is the local id.
REQ-011 m_resp_valid out, m_resp_ready in  NUM_MASTERS  per-master response handshake.
REQ-012 s_req_addr/wen/wdata/wmask/size/srcid/valid out, s_req_ready in  32/1/64/8/3/SRCID_W/1/1  downstream KL request.
REQ-013 s_resp_rdata/size/dstid/valid in, s_resp_ready out  64/3/SRCID_W/1/1  downstream KL response.

Function
REQ-014 Request stage SHALL be a single registered output slot; s_req_* driven only from it.
REQ-015 Slot accepts a new request in the same cycle it is empty or draining (s_req_valid & s_req_ready), giving 1-cycle request latency and full throughput.
REQ-016 Eligible master: m_req_valid[i] and (wen=1 or outst[i] < MAX_OUTST).
REQ-017 Round-robin arbitration: search starts at last_grant+1, wraps modulo NUM_MASTERS; first eligible master wins.
REQ-018 m_req_ready[i] SHALL be 1 only for the winner while the slot can accept; at most one ready asserted per cycle.
REQ-019 On acceptance: slot loads winner's fields, s_req_srcid = {winner index, local srcid}, last_grant <= winner.
REQ-020 While s_req_valid & !s_req_ready, all s_req_* SHALL hold stable.
REQ-021 Response path SHALL be combinational: idx = s_resp_dstid[SRCID_W-1 -: IDX_W]; m_resp_valid[idx] = s_resp_valid; s_resp_ready = m_resp_ready[idx]; m_resp_dstid = low LID_W bits.
REQ-022 Response with idx >= NUM_MASTERS SHALL be consumed (s_resp_ready=1) and dropped.
REQ-023 Per-master counter outst[i] (4 bits) SHALL increment on accepted read (wen=0), decrement on completed response handshake to master i.
REQ-024 Simultaneous increment and decrement for the same master SHALL leave outst[i] unchanged.
REQ-025 Decrement at outst[i]=0 SHALL saturate at 0 (no wrap).
REQ-026 Master at MAX_OUTST SHALL still be granted for writes.

Reset
REQ-027 On rst_n low, asynchronously: s_req_valid=0, all m_req_ready=0, outst[i]=0, last_grant=NUM_MASTERS-1 (so master 0 has first priority).
REQ-028 Reset mid-transaction SHALL discard the slot contents; no replay after reset release.
REQ-029 Response-path outputs are combinational and follow inputs during reset; s_req_* data fields are don't-care while s_req_valid=0.

Verification
REQ-030 Masters 0 and 1 read-valid continuously, s_req_ready=1 -> grants alternate 0,1,0,1; s_req_srcid upper IDX_W bits alternate 0,1 (for example with SRCID_W=5 and NUM_MASTERS=2, srcid bits [4] toggle).
REQ-031 s_req_ready=0 for 3 cycles with a request loaded -> s_req_* stable for those 3 cycles; all m_req_ready=0 during that time.
REQ-032 Master 0 issues MAX_OUTST=4 reads with no responses -> 5th read is not granted; one response to master 0 -> the next read is granted in the following cycle.
REQ-033 s_resp_dstid=5'b1_0011 with m_resp_ready[1]=1 -> m_resp_valid=2'b10, m_resp_dstid=4'b0011, s_resp_ready=1.
REQ-034 A read is accepted and a response to the same master occurs in the same cycle -> outst stays unchanged.
REQ-035 rst_n asserted while s_req_valid=1 -> s_req_valid=0 immediately; after release, master 0 wins the first arbitration.
